// File: rtl/mem_write_checker_if.sv
// Stimulus/observation bundle between a CPU test harness and mem_write_checker.
interface mem_write_checker_if #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 4
);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   // expectation loading and run control
   logic             ExpWe;
   logic [WIDTH-1:0] ExpAdr;
   logic [WIDTH-1:0] ExpData;
   logic             Start;

   // monitored CPU data-memory write port
   logic             MemWrite;
   logic [WIDTH-1:0] DataAdr;
   logic [WIDTH-1:0] WriteData;

   // checker status
   logic             ExpFull;
   logic             Busy;
   logic             Done;
   logic             Pass;
   logic [1:0]       FailCode;
   logic [CW-1:0]    MatchCount;
   logic [WIDTH-1:0] FailAdr;
   logic [WIDTH-1:0] FailData;

   modport master (
      output ExpWe, ExpAdr, ExpData, Start, MemWrite, DataAdr, WriteData,
      input  ExpFull, Busy, Done, Pass, FailCode, MatchCount, FailAdr, FailData
   );

   modport slave (
      input  ExpWe, ExpAdr, ExpData, Start, MemWrite, DataAdr, WriteData,
      output ExpFull, Busy, Done, Pass, FailCode, MatchCount, FailAdr, FailData
   );
endinterface

// File: rtl/mem_write_checker.sv
// Checks the CPU data-memory write stream against an ordered list of
// expected (address, data) pairs, with a scratch-address filter and a
// per-match watchdog. All status outputs are registered copies of the
// internal state, so they trail the sampling edge by one cycle.
module mem_write_checker #(
   parameter int unsigned WIDTH      = 32,
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned TIMEOUT    = 1024,
   parameter int unsigned IGNORE_EN  = 1,
   parameter int unsigned IGNORE_ADR = 96
) (
   input  logic              clk,
   input  logic              reset,
   mem_write_checker_if.slave bus
);
   localparam int unsigned CW  = $clog2(DEPTH + 1);
   localparam int unsigned IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned ASZ = 1 << IW;
   localparam int unsigned TW  = $clog2(TIMEOUT);

   localparam logic [1:0] CODE_NONE     = 2'd0;
   localparam logic [1:0] CODE_MISMATCH = 2'd1;
   localparam logic [1:0] CODE_TIMEOUT  = 2'd2;
   localparam logic [1:0] CODE_EMPTY    = 2'd3;

   typedef enum logic [1:0] {ST_LOAD, ST_RUN, ST_PASS, ST_FAIL} state_e;

   typedef struct packed {
      logic [WIDTH-1:0] adr;
      logic [WIDTH-1:0] data;
   } entry_t;

   state_e           state_q, state_d;
   entry_t           entry_q [ASZ];
   logic [CW-1:0]    count_q, count_d;
   logic [CW-1:0]    ptr_q, ptr_d;
   logic [TW-1:0]    timer_q, timer_d;
   logic [1:0]       code_q, code_d;
   logic [WIDTH-1:0] fadr_q, fadr_d;
   logic [WIDTH-1:0] fdata_q, fdata_d;
   logic             ent_we_c;

   logic             exp_full_q;
   logic             busy_q;
   logic             done_q;
   logic             pass_q;
   logic [1:0]       fail_code_q;
   logic [CW-1:0]    match_count_q;
   logic [WIDTH-1:0] fail_adr_q;
   logic [WIDTH-1:0] fail_data_q;

   // shared decode of the current cycle
   logic          full_c;
   logic          load_acc_c;
   logic [CW-1:0] eff_count_c;
   entry_t        cur_c;
   logic          hit_c;
   logic          ign_c;
   logic [CW-1:0] ptr_inc_c;
   logic          last_c;
   logic          tmo_c;

   assign full_c      = (count_q == CW'(DEPTH));
   assign load_acc_c  = (state_q == ST_LOAD) && bus.ExpWe && !full_c;
   assign eff_count_c = load_acc_c ? count_q + CW'(1) : count_q;
   assign cur_c       = entry_q[IW'(ptr_q)];
   assign hit_c       = bus.MemWrite && (bus.DataAdr == cur_c.adr)
                        && (bus.WriteData == cur_c.data);
   assign ign_c       = (IGNORE_EN != 0) && bus.MemWrite
                        && (bus.DataAdr == WIDTH'(IGNORE_ADR));
   assign ptr_inc_c   = ptr_q + CW'(1);
   assign last_c      = (ptr_inc_c == count_q);
   assign tmo_c       = (timer_q == TW'(TIMEOUT - 1));

   // state register
   always_ff @(posedge clk) begin
      if (reset) state_q <= ST_LOAD;
      else       state_q <= state_d;
   end

   // next-state logic; X on the monitored bus falls through to the mismatch branch
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_LOAD: begin
            if (bus.Start) state_d = (eff_count_c == '0) ? ST_FAIL : ST_RUN;
         end
         ST_RUN: begin
            if (hit_c) begin
               if (last_c) state_d = ST_PASS;
            end else if (ign_c) begin
               if (tmo_c) state_d = ST_FAIL;
            end else if (bus.MemWrite) begin
               state_d = ST_FAIL;
            end else if (tmo_c) begin
               state_d = ST_FAIL;
            end
         end
         ST_PASS, ST_FAIL: begin
            if (bus.Start) state_d = ST_RUN;
         end
         default: state_d = ST_LOAD;
      endcase
   end

   // datapath next values: list count, match pointer, watchdog, failure capture
   always_comb begin
      count_d  = count_q;
      ptr_d    = ptr_q;
      timer_d  = timer_q;
      code_d   = code_q;
      fadr_d   = fadr_q;
      fdata_d  = fdata_q;
      ent_we_c = 1'b0;
      case (state_q)
         ST_LOAD: begin
            if (load_acc_c) begin
               ent_we_c = 1'b1;
               count_d  = count_q + CW'(1);
            end
            if (bus.Start) begin
               ptr_d   = '0;
               timer_d = '0;
               if (eff_count_c == '0) code_d = CODE_EMPTY;
            end
         end
         ST_RUN: begin
            if (hit_c) begin
               ptr_d   = ptr_inc_c;
               timer_d = '0;
            end else if (ign_c) begin
               if (tmo_c) code_d  = CODE_TIMEOUT;
               else       timer_d = timer_q + TW'(1);
            end else if (bus.MemWrite) begin
               code_d  = CODE_MISMATCH;
               fadr_d  = bus.DataAdr;
               fdata_d = bus.WriteData;
            end else if (tmo_c) begin
               code_d = CODE_TIMEOUT;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         ST_PASS, ST_FAIL: begin
            if (bus.Start) begin
               ptr_d   = '0;
               timer_d = '0;
               code_d  = CODE_NONE;
            end
         end
         default: ;
      endcase
   end

   // datapath registers
   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
         ptr_q   <= '0;
         timer_q <= '0;
         code_q  <= CODE_NONE;
         fadr_q  <= '0;
         fdata_q <= '0;
      end else begin
         count_q <= count_d;
         ptr_q   <= ptr_d;
         timer_q <= timer_d;
         code_q  <= code_d;
         fadr_q  <= fadr_d;
         fdata_q <= fdata_d;
      end
   end

   // expectation storage; contents are only meaningful below count_q
   always_ff @(posedge clk) begin
      if (!reset && ent_we_c) begin
         entry_q[IW'(count_q)] <= '{adr: bus.ExpAdr, data: bus.ExpData};
      end
   end

   // registered status outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         exp_full_q    <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         pass_q        <= 1'b0;
         fail_code_q   <= CODE_NONE;
         match_count_q <= '0;
         fail_adr_q    <= '0;
         fail_data_q   <= '0;
      end else begin
         exp_full_q    <= full_c;
         busy_q        <= (state_q == ST_RUN);
         done_q        <= (state_q == ST_PASS) || (state_q == ST_FAIL);
         pass_q        <= (state_q == ST_PASS);
         fail_code_q   <= code_q;
         match_count_q <= ptr_q;
         fail_adr_q    <= fadr_q;
         fail_data_q   <= fdata_q;
      end
   end

   assign bus.ExpFull    = exp_full_q;
   assign bus.Busy       = busy_q;
   assign bus.Done       = done_q;
   assign bus.Pass       = pass_q;
   assign bus.FailCode   = fail_code_q;
   assign bus.MatchCount = match_count_q;
   assign bus.FailAdr    = fail_adr_q;
   assign bus.FailData   = fail_data_q;
endmodule

// File: tb/tb_mem_write_checker.sv
// Directed bench for mem_write_checker (DEPTH=4, TIMEOUT=8, scratch address 96).
module tb_mem_write_checker;
   localparam int unsigned W = 32;
   localparam int unsigned D = 4;

   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   mem_write_checker_if #(.WIDTH(W), .DEPTH(D)) bus ();

   mem_write_checker #(
      .WIDTH(W), .DEPTH(D), .TIMEOUT(8), .IGNORE_EN(1), .IGNORE_ADR(96)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      bus.ExpWe = 1'b0; bus.ExpAdr = '0; bus.ExpData = '0; bus.Start = 1'b0;
      bus.MemWrite = 1'b0; bus.DataAdr = '0; bus.WriteData = '0;
   endtask

   task automatic do_reset();
      reset = 1'b1; step(); step(); reset = 1'b0;
   endtask

   task automatic load(input logic [31:0] a, input logic [31:0] d);
      bus.ExpWe = 1'b1; bus.ExpAdr = a; bus.ExpData = d;
      step();
      bus.ExpWe = 1'b0;
   endtask

   task automatic start();
      bus.Start = 1'b1; step(); bus.Start = 1'b0;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      bus.MemWrite = 1'b1; bus.DataAdr = a; bus.WriteData = d;
      step();
      bus.MemWrite = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_full"},  32'(bus.ExpFull),    32'd0);
      check({tag, "_busy"},  32'(bus.Busy),       32'd0);
      check({tag, "_done"},  32'(bus.Done),       32'd0);
      check({tag, "_pass"},  32'(bus.Pass),       32'd0);
      check({tag, "_code"},  32'(bus.FailCode),   32'd0);
      check({tag, "_mcnt"},  32'(bus.MatchCount), 32'd0);
      check({tag, "_fadr"},  bus.FailAdr,         32'd0);
      check({tag, "_fdata"}, bus.FailData,        32'd0);
   endtask

   initial begin
      idle_in();
      reset = 1'b1;
      step(); step();
      reset = 1'b0;
      check_all_zero("rst");

      // single entry with a tolerated scratch write in front
      load(32'd100, 32'd7);
      start();
      wr(32'd96, 32'd3);
      check("t1_busy", 32'(bus.Busy), 32'd1);
      step(); step();
      wr(32'd100, 32'd7);
      check("t1_pass_lag", 32'(bus.Pass), 32'd0);
      step();
      check("t1_pass", 32'(bus.Pass),       32'd1);
      check("t1_done", 32'(bus.Done),       32'd1);
      check("t1_mcnt", 32'(bus.MatchCount), 32'd1);
      check("t1_code", 32'(bus.FailCode),   32'd0);
      check("t1_busy_end", 32'(bus.Busy),   32'd0);

      // expected entry at the scratch address is a real match
      do_reset();
      load(32'd96, 32'd5);
      load(32'd100, 32'd7);
      start();
      wr(32'd96, 32'd5);
      wr(32'd100, 32'd7);
      step();
      check("t2_pass", 32'(bus.Pass),       32'd1);
      check("t2_mcnt", 32'(bus.MatchCount), 32'd2);

      // mismatching write is captured
      do_reset();
      load(32'd100, 32'd7);
      start();
      wr(32'd104, 32'd9);
      step();
      check("t3_done", 32'(bus.Done),       32'd1);
      check("t3_pass", 32'(bus.Pass),       32'd0);
      check("t3_code", 32'(bus.FailCode),   32'd1);
      check("t3_fadr", bus.FailAdr,         32'd104);
      check("t3_fdat", bus.FailData,        32'd9);
      check("t3_mcnt", 32'(bus.MatchCount), 32'd0);

      // restart from FAIL keeps the capture, clears the code, then passes
      start();
      step();
      check("t3r_busy", 32'(bus.Busy),     32'd1);
      check("t3r_code", 32'(bus.FailCode), 32'd0);
      check("t3r_fadr", bus.FailAdr,       32'd104);
      wr(32'd100, 32'd7);
      step();
      check("t3r_pass", 32'(bus.Pass),     32'd1);

      // watchdog: Done rises 9 cycles after the Start edge
      do_reset();
      load(32'd100, 32'd7);
      start();
      for (int i = 0; i < 8; i++) step();
      check("t4_done_early", 32'(bus.Done), 32'd0);
      step();
      check("t4_done", 32'(bus.Done),     32'd1);
      check("t4_code", 32'(bus.FailCode), 32'd2);
      start();
      wr(32'd100, 32'd7);
      step();
      check("t4_pass", 32'(bus.Pass),     32'd1);
      check("t4_code_clr", 32'(bus.FailCode), 32'd0);

      // list capacity: fifth load dropped
      do_reset();
      load(32'd10, 32'd1);
      load(32'd20, 32'd2);
      load(32'd30, 32'd3);
      load(32'd40, 32'd4);
      check("t5_full_lag", 32'(bus.ExpFull), 32'd0);
      load(32'd50, 32'd5);
      check("t5_full", 32'(bus.ExpFull), 32'd1);
      start();
      wr(32'd10, 32'd1);
      wr(32'd20, 32'd2);
      wr(32'd30, 32'd3);
      wr(32'd40, 32'd4);
      check("t5_mcnt3", 32'(bus.MatchCount), 32'd3);
      step();
      check("t5_pass", 32'(bus.Pass),       32'd1);
      check("t5_mcnt", 32'(bus.MatchCount), 32'd4);

      // load accepted in the same cycle as Start counts
      do_reset();
      bus.ExpWe = 1'b1; bus.ExpAdr = 32'd200; bus.ExpData = 32'd11; bus.Start = 1'b1;
      step();
      idle_in();
      step();
      check("t6_busy", 32'(bus.Busy), 32'd1);
      wr(32'd200, 32'd11);
      step();
      check("t6_pass", 32'(bus.Pass), 32'd1);

      // empty list
      do_reset();
      start();
      step();
      check("t7_done", 32'(bus.Done),     32'd1);
      check("t7_code", 32'(bus.FailCode), 32'd3);

      // reset in RUN after two matches
      do_reset();
      load(32'd10, 32'd1);
      load(32'd20, 32'd2);
      load(32'd30, 32'd3);
      start();
      wr(32'd10, 32'd1);
      wr(32'd20, 32'd2);
      step();
      check("t8_mcnt", 32'(bus.MatchCount), 32'd2);
      check("t8_busy", 32'(bus.Busy),       32'd1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check_all_zero("t8_rst");
      start();
      step();
      check("t8_empty", 32'(bus.FailCode), 32'd3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/mem_write_checker.md
# mem_write_checker

Synthesizable, parametrised self-check block for the CPU test harness. It watches the data-memory write port of `cpu_main` (`MemWrite`, `DataAdr`, `WriteData`) and compares each write against a programmed ordered list of up to `DEPTH` expected (address, data) pairs. A configurable scratch address is tolerated, and a watchdog limits the cycles allowed between matches. It reports pass/fail, failure cause and the offending write, so one bench or FPGA build can check multi-write programs instead of a single final store.

## Interface
- `WIDTH`, 32, address/data width.
- `DEPTH`, 4, maximum number of expected writes (≥1).
- `TIMEOUT`, 1024, maximum cycles allowed in RUN without a match (≥2).
- `IGNORE_EN`, 1, enables tolerance of writes to `IGNORE_ADR`.
- `IGNORE_ADR`, 96, scratch address whose non-matching writes are ignored.

Ports:
- `clk`  in  1  clock. One clock domain; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `ExpWe`  in  1  loads one expected entry.
- `ExpAdr`  in  WIDTH  expected address.
- `ExpData`  in  WIDTH  expected data.
- `Start`  in  1  begins or restarts checking.
- `MemWrite`  in  1  monitored write strobe.
- `DataAdr`  in  WIDTH  monitored address.
- `WriteData`  in  WIDTH  monitored data.
- `ExpFull`  out  1  expectation list holds `DEPTH` entries.
- `Busy`  out  1  state is RUN.
- `Done`  out  1  state is PASS or FAIL.
- `Pass`  out  1  state is PASS.
- `FailCode`  out  2  0 none, 1 mismatch, 2 timeout, 3 empty list.
- `MatchCount`  out  $clog2(DEPTH+1)  entries matched so far.
- `FailAdr`  out  WIDTH  `DataAdr` of the mismatching write.
- `FailData`  out  WIDTH  `WriteData` of the mismatching write.

## Operation
- States: LOAD, RUN, PASS, FAIL. Reset enters LOAD and clears the following:
  - entry count, match pointer and timer;
  - `ExpFull`, `Busy`, `Done`, `Pass`;
  - `FailCode`, `MatchCount`, `FailAdr`, `FailData`.
- LOAD behaviour:
  - `ExpWe` with count < `DEPTH` writes the entry at index count, then count+1.
  - `ExpWe` when full is dropped; entries and count are unchanged.
  - `ExpWe` outside LOAD is ignored.
  - `MemWrite` is ignored.
- `Start` in LOAD transitions as follows:
  - With an effective count of 0, go to FAIL, code 3.
  - Otherwise go to RUN, with pointer=0 and timer=0.
  - Effective count includes an `ExpWe` accepted in the same cycle.
- RUN behaviour, evaluated each cycle in this priority order:
  1. `MemWrite` and (`DataAdr`,`WriteData`) equal entry[pointer]: pointer+1, timer=0. If pointer+1 == count, go to PASS.
  2. `MemWrite`, `IGNORE_EN`=1 and `DataAdr`==`IGNORE_ADR`: no effect; timer continues.
  3. `MemWrite` otherwise: go to FAIL, code 1, and capture `FailAdr`/`FailData`.
  4. No match this cycle and timer == `TIMEOUT`-1: go to FAIL, code 2. Otherwise timer+1.
- A write that matches the expected entry but is at the ignore address counts as a match (rule 1 wins).
- PASS and FAIL are sticky:
  - `Start` in PASS/FAIL re-enters RUN with the same list; pointer, timer and `FailCode` are cleared, `FailAdr`/`FailData` are kept.
  - `Start` in RUN is ignored.
- `MatchCount` equals the pointer. It holds its value in PASS/FAIL and clears on restart.
- Compares are full `WIDTH`-bit equality. X/Z on monitored inputs while `MemWrite`=1 counts as a mismatch, matching the bench's `!==` semantics.

## Timing
- All outputs are registered. Status reflects a sampled event one cycle later.
- `Done`/`Pass` rise in the cycle after the edge that sampled the final matching write.
- Timeout: with no matches, `Done` rises exactly `TIMEOUT`+1 cycles after the `Start` edge.
- `reset` has priority over every input, in any state, including mid-RUN.
- `ExpFull` updates the cycle after the `DEPTH`-th accepted load.

## Test plan
- Load one entry (100,7) and Start. Drive writes (96,3), then (100,7) three cycles later. Required: `Pass`=1, `MatchCount`=1, `FailCode`=0, one cycle after the sampled match.
- Load (96,5),(100,7) with `IGNORE_EN`=1. Write (96,5), then (100,7). Required: PASS, `MatchCount`=2, because the ignore address is matched as an expected entry.
- Load (100,7). Write (104,9). Required: FAIL, `FailCode`=1, `FailAdr`=104, `FailData`=9, `MatchCount`=0.
- `TIMEOUT`=8, one entry loaded, no writes. Required: `Done` rises 9 cycles after the Start edge with `FailCode`=2. Then Start again and write the entry: PASS.
- `DEPTH`=4: load 5 entries. Required: `ExpFull`=1 after the 4th and the 5th is dropped. Matching the 4 entries in order gives PASS with `MatchCount`=4.
- Start with an empty list gives FAIL code 3. Reset during RUN after 2 matches returns all outputs to 0 and LOAD with count 0.
